// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: opsel codes, FSM state, flags.
package alu_pkg;

  localparam int DWIDTH_DEF = 32;

  // ALU opsel encoding (must match the ALU instantiated by the parent)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;

  // Flag vector as presented on resp_flags: {c,z,o,s}
  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic s;
  } alu_flags_t;

endpackage

// File: rtl/alu_resp_reg.sv
// Capture/hold register for ALU result and flags.
// Optional sticky overflow under ALU_SEQ_STICKY_OVF_EN.
import alu_pkg::*;

module alu_resp_reg #(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DWIDTH-1:0] result,
  input  alu_flags_t        flags,
`ifdef ALU_SEQ_STICKY_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf_sticky,
`endif
  output logic [DWIDTH-1:0] resp_result,
  output alu_flags_t        resp_flags
);

  // Capture only at the edge ending EXEC; hold otherwise so the response is stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result <= '0;
      resp_flags  <= '0;
    end else if (capture) begin
      resp_result <= result;
      resp_flags  <= flags;
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Sticky overflow: a capture with o=1 wins over a same-edge clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovf_sticky <= 1'b0;
    else if (capture && flags.o) ovf_sticky <= 1'b1;
    else if (ovf_clr)           ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer between datapath control and the combinational ALU.
// Accepts a request, drives the ALU for one cycle, captures and presents the result.
// Optional: ALU_SEQ_STICKY_OVF_EN adds ovf_clr / ovf_sticky.
import alu_pkg::*;

module alu_op_sequencer #(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DWIDTH-1:0] req_op1,
  input  logic [DWIDTH-1:0] req_op2,
  input  logic [2:0]        req_opsel,
  input  logic              req_mode,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_result,
  output logic [3:0]        resp_flags,
`ifdef ALU_SEQ_STICKY_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf_sticky,
`endif
  output logic              busy
);

  seq_state_t state, nxt;
  logic       accept;
  alu_flags_t cap_flags;
  alu_flags_t held_flags;

  assign req_ready  = (state == IDLE) || (state == RESP && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign cap_flags  = '{c: alu_c, z: alu_z, o: alu_o, s: alu_s};
  assign resp_flags = held_flags;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: one EXEC cycle per op, RESP holds until consumed
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = EXEC;
      EXEC:    nxt = RESP;
      RESP:    if (resp_ready) nxt = accept ? EXEC : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request latch doubles as the ALU input drive; it moves only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op1   <= '0;
      alu_op2   <= '0;
      alu_opsel <= '0;
      alu_mode  <= 1'b0;
    end else if (accept) begin
      alu_op1   <= req_op1;
      alu_op2   <= req_op2;
      alu_opsel <= req_opsel;
      alu_mode  <= req_mode;
    end
  end

  alu_resp_reg #(.DWIDTH(DWIDTH)) u_resp (
    .clk         (clk),
    .rst         (rst),
    .capture     (state == EXEC),
    .result      (alu_result),
    .flags       (cap_flags),
`ifdef ALU_SEQ_STICKY_OVF_EN
    .ovf_clr     (ovf_clr),
    .ovf_sticky  (ovf_sticky),
`endif
    .resp_result (resp_result),
    .resp_flags  (held_flags)
  );

endmodule
